// File: rtl/bram_stream_reader.sv
// bram_stream_reader
// Walks the read port of a registered-output block RAM from a base address
// for a given word count and replays the words on a valid/ready stream with
// last-beat marking. A 2-entry output FIFO plus a one-bit in-flight flag
// absorbs the RAM's one-cycle read latency without losing data under
// arbitrary backpressure.

module bram_stream_reader #(
  parameter int SIZE = 256,
  localparam int AW = $clog2(SIZE)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   length,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] ram_rd_addr,
  output logic          ram_rd_en,
  input  logic [31:0]   ram_rd_data,
  output logic [31:0]   out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state;
  logic [AW:0]   len;           // latched word count
  logic [AW:0]   issued;        // reads issued so far
  logic [AW:0]   accepted;      // beats accepted downstream so far
  logic          inflight;      // a read was issued last cycle; data on ram_rd_data now
  logic          inflight_last; // that read is the final word of the transfer

  // FIFO: entry 0 is the output registers themselves, entry 1 is the spare.
  logic [1:0]    fifo_count;
  logic [31:0]   data1;
  logic          last1;

  logic          pop;
  logic          push;
  logic          issue_last;
  logic [1:0]    count_next;

  // Handshake, read-issue credit check and FIFO occupancy for the next edge.
  // The credit check counts words already committed (FIFO + in flight) minus
  // the beat leaving this cycle, so a new read always finds a free slot when
  // its data lands two edges later.
  always_comb begin
    pop        = out_valid && out_ready;
    push       = inflight;
    ram_rd_en  = 1'b0;
    issue_last = 1'b0;
    if (state == ISSUE) begin
      ram_rd_en = (({1'b0, fifo_count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));
    end else begin
      ram_rd_en = 1'b0;
    end
    if (ram_rd_en && (issued == (len - (AW+1)'(1)))) begin
      issue_last = 1'b1;
    end else begin
      issue_last = 1'b0;
    end
    count_next = fifo_count + {1'b0, push} - {1'b0, pop};
  end

  // Transfer sequencer: address walk, counters, busy/done and in-flight tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      len           <= '0;
      issued        <= '0;
      accepted      <= '0;
      ram_rd_addr   <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      done          <= 1'b0;
      inflight      <= ram_rd_en;
      inflight_last <= issue_last;

      if (ram_rd_en) begin
        issued      <= issued + (AW+1)'(1);
        // AW-bit add: the carry is dropped so the walk wraps SIZE-1 -> 0.
        ram_rd_addr <= ram_rd_addr + AW'(1);
      end

      if (pop) begin
        accepted <= accepted + (AW+1)'(1);
      end

      case (state)
        IDLE: begin
          // A start coinciding with the done pulse is deliberately ignored.
          if (start && !done) begin
            if (length != '0) begin
              state       <= ISSUE;
              len         <= length;
              issued      <= '0;
              accepted    <= '0;
              ram_rd_addr <= base_addr;
              busy        <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (issue_last) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && (accepted == (len - (AW+1)'(1)))) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Output FIFO: push the in-flight RAM word unconditionally, shift on pop.
  // The head lives directly in out_data/out_last so the stream is registered
  // and holds steady while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_count <= 2'd0;
      out_data   <= 32'd0;
      out_last   <= 1'b0;
      out_valid  <= 1'b0;
      data1      <= 32'd0;
      last1      <= 1'b0;
    end else begin
      fifo_count <= count_next;
      out_valid  <= (count_next != 2'd0);
      case ({push, pop})
        2'b10: begin
          if (fifo_count == 2'd0) begin
            out_data <= ram_rd_data;
            out_last <= inflight_last;
          end else begin
            data1 <= ram_rd_data;
            last1 <= inflight_last;
          end
        end
        2'b01: begin
          if (fifo_count == 2'd2) begin
            out_data <= data1;
            out_last <= last1;
          end else begin
            out_last <= 1'b0;
          end
        end
        2'b11: begin
          if (fifo_count == 2'd2) begin
            out_data <= data1;
            out_last <= last1;
            data1    <= ram_rd_data;
            last1    <= inflight_last;
          end else begin
            out_data <= ram_rd_data;
            out_last <= inflight_last;
          end
        end
        default: begin
          out_data <= out_data;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed self-checking bench for bram_stream_reader with a behavioural
// registered-read RAM preloaded with 0xA000_0000 + index.

module tb_bram_stream_reader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  base_addr;
  logic [8:0]  length;
  logic        busy;
  logic        done;
  logic [7:0]  ram_rd_addr;
  logic        ram_rd_en;
  logic [31:0] ram_rd_data;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  logic [31:0] mem [0:255];

  int checks;
  int failures;

  bram_stream_reader #(.SIZE(256)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .base_addr   (base_addr),
    .length      (length),
    .busy        (busy),
    .done        (done),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_en   (ram_rd_en),
    .ram_rd_data (ram_rd_data),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read RAM; returns garbage when no read is issued.
  always_ff @(posedge clk) begin
    if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
    else           ram_rd_data <= 32'hDEAD_BEEF;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transfer: start in cycle 0, then per-cycle scoreboard of addresses,
  // beats, stall behaviour, busy/done timing.
  task automatic run(input logic [7:0] b, input logic [8:0] n, input bit toggle, input bit poke);
    int beats, issued, last_cyc, first_cyc, done_cnt, pend, max_pend;
    bit stalled;
    bit rdy;
    logic [5:0] pat;
    logic [7:0] exp_addr;
    logic [7:0] exp_idx;
    logic [31:0] expw;
    pat = 6'b011001;
    beats = 0; issued = 0; last_cyc = -1; first_cyc = -1;
    done_cnt = 0; pend = 0; max_pend = 0; stalled = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      start     = (cyc == 0) || (poke && (cyc == 4 || (last_cyc >= 0 && cyc == last_cyc + 1)));
      base_addr = (cyc == 0) ? b : 8'd100;
      length    = (cyc == 0) ? n : 9'd5;
      rdy       = toggle ? pat[cyc % 6] : 1'b1;
      out_ready = rdy;
      #1;
      if (cyc == 1 && n != 9'd0) begin
        check("c1_busy", {31'd0, busy}, 32'd1);
        check("c1_rd_en", {31'd0, ram_rd_en}, 32'd1);
        check("c1_rd_addr", {24'd0, ram_rd_addr}, {24'd0, b});
      end
      if (n == 9'd0 && cyc >= 1) begin
        check("len0_busy", {31'd0, busy}, 32'd0);
        check("len0_valid", {31'd0, out_valid}, 32'd0);
        check("len0_done", {31'd0, done}, (cyc == 1) ? 32'd1 : 32'd0);
      end
      if (ram_rd_en) begin
        exp_addr = b + issued[7:0];
        check("rd_addr", {24'd0, ram_rd_addr}, {24'd0, exp_addr});
        issued++;
        pend++;
      end
      if (stalled) check("stall_valid", {31'd0, out_valid}, 32'd1);
      if (out_valid) begin
        exp_idx = b + beats[7:0];
        expw = 32'hA000_0000 | {24'd0, exp_idx};
        check("out_data", out_data, expw);
        check("out_last", {31'd0, out_last}, (beats == int'(n) - 1) ? 32'd1 : 32'd0);
        if (first_cyc < 0) first_cyc = cyc;
        if (rdy) begin
          beats++;
          pend--;
          if (beats == int'(n)) last_cyc = cyc;
        end
      end
      stalled = out_valid && !rdy;
      if (pend > max_pend) max_pend = pend;
      if (done) done_cnt++;
      if (last_cyc >= 0 && cyc == last_cyc + 1) begin
        check("end_busy", {31'd0, busy}, 32'd0);
        check("end_done", {31'd0, done}, 32'd1);
      end
      if (last_cyc >= 0 && cyc == last_cyc + 2) begin
        check("post_done", {31'd0, done}, 32'd0);
        check("post_busy", {31'd0, busy}, 32'd0);
        check("post_rd_en", {31'd0, ram_rd_en}, 32'd0);
        break;
      end
      if (n == 9'd0 && cyc == 3) break;
    end
    start = 1'b0;
    if (n != 9'd0) begin
      check("timeout", (last_cyc >= 0) ? 32'd1 : 32'd0, 32'd1);
      if (!toggle) begin
        check("first_beat_cycle", first_cyc, 32'd3);
        check("last_beat_cycle", last_cyc, 32'd2 + {23'd0, n});
      end
    end
    check("beat_count", beats, {23'd0, n});
    check("issue_count", issued, {23'd0, n});
    check("done_count", done_cnt, 32'd1);
    check("max_pending", (max_pend <= 2) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + i;
    rst_n = 1'b0; start = 1'b0; base_addr = 8'd0; length = 9'd0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_last", {31'd0, out_last}, 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_rd_en", {31'd0, ram_rd_en}, 32'd0);
    check("rst_rd_addr", {24'd0, ram_rd_addr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run(8'd4,   9'd8, 1'b0, 1'b0);   // basic timing
    run(8'd254, 9'd4, 1'b0, 1'b0);   // address wrap
    run(8'd10,  9'd8, 1'b1, 1'b0);   // backpressure 1,0,0,1,1,0
    run(8'd7,   9'd0, 1'b0, 1'b0);   // zero length
    run(8'd30,  9'd6, 1'b0, 1'b1);   // start pulses mid-transfer and in done cycle

    // Async reset at beat 3 of a 16-word transfer from base 20.
    @(negedge clk);
    start = 1'b1; base_addr = 8'd20; length = 9'd16; out_ready = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1;
    check("pre_rst_beat3", out_data, 32'hA000_0017);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_valid", {31'd0, out_valid}, 32'd0);
    check("abort_last", {31'd0, out_last}, 32'd0);
    check("abort_data", out_data, 32'd0);
    check("abort_rd_en", {31'd0, ram_rd_en}, 32'd0);
    check("abort_rd_addr", {24'd0, ram_rd_addr}, 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      check("abort_no_done", {31'd0, done}, 32'd0);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      check("after_rst_no_done", {31'd0, done}, 32'd0);
    end
    run(8'd0, 9'd2, 1'b0, 1'b0);     // fresh transfer after abort

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bram_stream_reader.md
# bram_stream_reader

Read-side sequencer for the 32-bit dual-port block RAM. Given a base address and word count, it walks the RAM read port, absorbs the RAM's one-cycle registered read latency, and presents the words in order on a valid/ready stream with last-beat marking. It sits between a block RAM that another agent has filled and any downstream consumer that can apply backpressure.

## Interface
- SIZE, 256: RAM depth in words; must match the attached RAM. AW = `LOG2(SIZE)`.
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- base_addr  in  AW  first word address; sampled with start.
- length  in  AW+1  word count, 0..SIZE; sampled with start.
- busy  out  1  high from the cycle after an accepted start with length>0 until the last beat is accepted.
- done  out  1  one-cycle pulse at transfer completion.
- ram_rd_addr  out  AW  to RAM rd_addr.
- ram_rd_en  out  1  high in cycles where a read is issued.
- ram_rd_data  in  32  from RAM rd_data; registered, valid the cycle after the address is presented.
- out_data  out  32  stream data.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready; beat transfers when out_valid && out_ready.
- out_last  out  1  high with the final beat of a transfer.

## Operation
- The RAM clk_en is tied high by the integrator. The reader never depends on the RAM holding rd_data.
- FSM states:
  - IDLE:
    - start && length>0 → ISSUE; latch base_addr, length.
    - start && length==0 → stay IDLE; done pulses next cycle; no beats.
  - ISSUE: issues one read per permitted cycle. ram_rd_addr = (base + issued) mod SIZE, so addresses wrap from SIZE-1 to 0. → DRAIN in the cycle after the length-th read is issued.
  - DRAIN: no reads. → IDLE on acceptance of the out_last beat; done pulses in the following cycle.
- Output buffer:
  - 2-entry FIFO, plus a 1-bit in-flight flag for a read issued in the previous cycle.
  - A read is issued when in ISSUE and (count + inflight − pop) < 2, where pop is the current handshake.
  - This gives 1 beat/cycle under continuous out_ready and no data loss under any out_ready pattern.
  - An in-flight read is written to the FIFO unconditionally on the next edge.
- out_data/out_valid/out_last are driven from the FIFO head.
- out_last is carried per entry and set on the word whose index equals length−1.
- Counters:
  - issued and accepted counters are AW+1 bits wide.
  - The address adder is AW bits and discards its carry.
- start while busy, or in the done cycle, is ignored.
- Outputs do not change while out_valid && !out_ready.

## Timing
- Reset values: busy=0, done=0, out_valid=0, out_last=0, out_data=0, ram_rd_en=0, ram_rd_addr=0. FIFO is empty, in-flight flag is clear, FSM is in IDLE.
- An async rst_n assertion mid-transfer aborts the transfer immediately: all outputs go to their reset values, no done pulse is issued, and data in flight is discarded.
- Cycle numbering: start high in cycle 0.
  - Cycle 1: busy=1, ram_rd_en=1, ram_rd_addr=base.
  - Cycle 2: ram_rd_data valid.
  - Cycle 3: out_valid=1 with word[base].
- With out_ready held high, beat k appears in cycle 3+k. The final beat is in cycle 2+length.
- busy falls in the cycle after the last handshake; done is high in that same cycle.
- A new start is accepted at the earliest in the cycle after done.

## Test plan
- Preload RAM[i]=0xA000_0000+i. Run base=4, length=8, ready=1 → words 0xA000_0004..0xA000_000B in cycles 3..10. out_last only on 0xA000_000B. done pulse in cycle 11.
- Run base=SIZE−2=254, length=4 → addresses 254,255,0,1 in order. Data matches; no extra beats.
- Run length=8 with out_ready toggling 1,0,0,1,1,0 repeating → all 8 words in order, none dropped or duplicated. Outputs stable while stalled. ram_rd_en never leaves more than 2 words pending.
- Run length=0 → done=1 in cycle 1. busy and out_valid stay 0.
- Pulse start again mid-transfer with a different base → ignored; the original sequence completes unchanged.
- Drop rst_n at beat 3 of length=16 → all outputs reach reset values immediately and no done pulse occurs. A fresh start with base=0, length=2 then yields RAM[0], RAM[1].
